accum_12bits: RTL

Sequential accumulator that sits directly downstream of the 12-bit ripple adder and drives its operands. It accepts a stream of 12-bit samples with carry-in over a valid/ready handshake, sums a fixed block of N_SAMPLES samples through the adder, and presents the block total plus an overflow flag on a valid/ready output. After the total is consumed it clears and starts the next block.

---
 rtl/accum_pkg.sv | 20 ++
 rtl/accum_12bits_adder.sv | 22 ++
 rtl/accum_12bits.sv | 125 ++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared types and widths for the 12-bit block accumulator.
package accum_pkg;

  localparam int unsigned ACC_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam logic [ACC_W-1:0] SAT_VAL = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Block result as presented on the output side.
  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] sum;
  } result_t;

endpackage

// File: rtl/accum_12bits_adder.sv
// Adder_12bits: 12-bit ripple-carry adder, s = a + b + cin with carry-out co.
module Adder_12bits (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        cin,
  output logic [11:0] s,
  output logic        co
);

  logic [12:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 12; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[12];

endmodule

// File: rtl/accum_12bits.sv
// Block accumulator: sums N_SAMPLES handshaked samples through Adder_12bits.
// Optional build macro ACCUM_SAT_EN clamps acc to 12'hFFF on carry-out.
module accum_12bits
  import accum_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  input  logic        in_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic        out_ovf,
  output logic        busy
);

  if ((N_SAMPLES < 1) || (N_SAMPLES > 255)) begin : g_bad_n
    $error("accum_12bits: N_SAMPLES must be in 1..255");
  end

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_s;
  logic             add_co;
  logic [ACC_W-1:0] acc_new;
  logic [CNT_W-1:0] cnt_inc;
  result_t          res;

  // Operand A is forced to zero while no block is open.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;

  Adder_12bits u_adder (
    .a   (add_a),
    .b   (in_data),
    .cin (in_cin),
    .s   (add_s),
    .co  (add_co)
  );

`ifdef ACCUM_SAT_EN
  assign acc_new = add_co ? SAT_VAL : add_s;
`else
  assign acc_new = add_s;
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = acc_new;
          ovf_d   = add_co;
          cnt_d   = CNT_W'(1);
          state_d = (N_CNT == CNT_W'(1)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = acc_new;
          ovf_d = ovf_q | add_co;
          cnt_d = cnt_inc;
          if (cnt_inc == N_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and state-decoded handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      in_ready  <= (state_d != DONE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign res     = '{ovf: ovf_q, sum: acc_q};
  assign out_sum = res.sum;
  assign out_ovf = res.ovf;

endmodule
